ascon_frame_packer: RTL

- Upstream stage of the ASCON encryption FSM.
- Collects a stream of ECG sample bytes into one plaintext frame, appends ASCON padding (0x80, then 0x00 bytes), and presents the frame on plain_text_o.
- Pulses start_o for one cycle once the frame is complete, then holds the frame stable until the encryptor reports done.

---
 rtl/ascon_frame_packer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ascon_frame_packer.sv
// Packs a byte stream into one ASCON-padded plaintext frame and hands it to the encryptor.
// Optional inter-byte timeout enabled by defining ASCON_PACKER_TIMEOUT_EN.
module ascon_frame_packer #(
  parameter int DATA_BYTES     = 181,
  parameter int FRAME_BYTES    = 184,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic [7:0]                         byte_i,
  input  logic                               byte_valid_i,
  input  logic                               flush_i,
  input  logic                               done_i,
  output logic                               ready_o,
  output logic                               start_o,
  output logic [8*FRAME_BYTES-1:0]           plain_text_o,
  output logic [$clog2(FRAME_BYTES+1)-1:0]   count_o,
  output logic                               error_o
);

  localparam int CW = $clog2(FRAME_BYTES+1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_BYTES - 1);
  localparam logic [CW-1:0] PAD_FIRST  = CW'(DATA_BYTES);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {COLLECT, PAD, START, WAIT_DONE} state_e;

  state_e                              state_q, state_d;
  logic [FRAME_BYTES-1:0][7:0]         frame_q, frame_d;
  logic [CW-1:0]                       count_q, count_d;
  logic                                start_q, start_d;
  logic                                error_q, error_d;
  logic                                accept;
  logic                                timeout;

  assign ready_o      = (state_q == COLLECT);
  assign accept       = byte_valid_i & ready_o;
  assign start_o      = start_q;
  assign error_o      = error_q;
  assign plain_text_o = frame_q;
  assign count_o      = count_q;

`ifdef ASCON_PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] idle_q, idle_d;

  // Only a partially filled frame can time out; any other condition parks the counter at 0.
  always_comb begin
    idle_d  = '0;
    timeout = 1'b0;
    if (state_q == COLLECT && count_q != '0 && count_q < PAD_FIRST && !accept && !flush_i) begin
      if (idle_q == TW'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
      else                                   idle_d  = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) idle_q <= '0;
    else          idle_q <= idle_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= COLLECT;
      frame_q <= '0;
      count_q <= '0;
      start_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      count_q <= count_d;
      start_q <= start_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT:   if (accept && count_q == DATA_LAST) state_d = PAD;
      PAD:       if (count_q == FRAME_LAST)          state_d = START;
      START:     state_d = WAIT_DONE;
      WAIT_DONE: if (done_i)                         state_d = COLLECT;
      default:   state_d = COLLECT;
    endcase
    if (flush_i || timeout) state_d = COLLECT;
  end

  always_comb begin
    frame_d = frame_q;
    count_d = count_q;
    if (flush_i || timeout) begin
      frame_d = '0;
      count_d = '0;
    end else begin
      case (state_q)
        COLLECT: if (accept) begin
          frame_d = {frame_q[FRAME_BYTES-2:0], byte_i};
          count_d = count_q + 1'b1;
        end
        // First pad byte carries the 0x80 marker, the rest are zero.
        PAD: begin
          frame_d = {frame_q[FRAME_BYTES-2:0], (count_q == PAD_FIRST) ? 8'h80 : 8'h00};
          count_d = count_q + 1'b1;
        end
        WAIT_DONE: if (done_i) begin
          frame_d = '0;
          count_d = '0;
        end
        default: ;
      endcase
    end
    start_d = (state_d == START);
    error_d = timeout;
  end

endmodule
